// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart_tx handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if;
    logic [7:0] req0_data_i;
    logic       req0_valid_i;
    logic       req0_ready_o;
    logic [7:0] req1_data_i;
    logic       req1_valid_i;
    logic       req1_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_ready_o;
    logic       tx_valid_i;
    logic       grant_o;
    logic       busy_o;
    logic       timeout_o;

    modport slave (
        input  req0_data_i, req0_valid_i, req1_data_i, req1_valid_i, tx_valid_i,
        output req0_ready_o, req1_ready_o, tx_data_o, tx_ready_o, grant_o, busy_o, timeout_o
    );

    modport master (
        output req0_data_i, req0_valid_i, req1_data_i, req1_valid_i, tx_valid_i,
        input  req0_ready_o, req1_ready_o, tx_data_o, tx_ready_o, grant_o, busy_o, timeout_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin arbiter feeding one uart_tx
module uart_tx_arbiter #(
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 125000
) (
    input logic               clk_i,
    input logic               nreset_i,
    uart_tx_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        grant_q, grant_d;
    logic        last_q, last_d;
    logic        take0, take1, timeout;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            tx_data_q <= 8'h00;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        last_d    = last_q;
        take0     = 1'b0;
        take1     = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                // On contention the requester that did not own the last frame wins.
                take0 = bus.req0_valid_i && (!bus.req1_valid_i || last_q);
                take1 = bus.req1_valid_i && (!bus.req0_valid_i || !last_q);
                if (take0 || take1) begin
                    tx_data_d = take0 ? bus.req0_data_i : bus.req1_data_i;
                    grant_d   = take1;
                    last_d    = take1;
                    cnt_d     = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                // Completion takes priority over a timeout landing on the same cycle.
                if (bus.tx_valid_i) begin
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = GAP;
                end else if (cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                    cnt_d   = '0;
                    gap_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req0_ready_o = take0;
    assign bus.req1_ready_o = take1;
    assign bus.tx_data_o    = tx_data_q;
    assign bus.tx_ready_o   = (state_q == SEND);
    assign bus.grant_o      = grant_q;
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.timeout_o    = timeout;
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CYC, default 2: idle cycles with tx_ready_o low between frames; legal range 1..255.
REQ-002 Parameter TIMEOUT_CYC, default 125000: maximum SEND cycles to wait for tx_valid_i; legal range 2..2^20-1.
REQ-003 One clock; reset is asynchronous and active-low; ports: clk_i (clock), nreset_i (reset).
REQ-004 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-005 nreset_i  input  1  asynchronous active-low reset.
REQ-006 req0_data_i  input  8  byte offered by requester 0.
REQ-007 req0_valid_i  input  1  requester 0 has a byte on req0_data_i.
REQ-008 req0_ready_o  output  1  arbiter accepts the requester 0 byte this cycle.
REQ-009 req1_data_i / req1_valid_i / req1_ready_o  8 / 1 / 1  same as REQ-006..008 for requester 1.
REQ-010 tx_data_o  output  8  byte driven to uart_tx tx_data_i.
REQ-011 tx_ready_o  output  1  drives uart_tx ready_i; high requests a frame.
REQ-012 tx_valid_i  input  1  from uart_tx valid_o; one-cycle pulse at frame completion.
REQ-013 grant_o  output  1  index of the requester owning the current or last frame.
REQ-014 busy_o  output  1  high in any state other than IDLE.
REQ-015 timeout_o  output  1  one-cycle pulse when a frame is abandoned.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, SEND and GAP.
REQ-017 Upstream transfer SHALL occur on a cycle where reqN_valid_i and reqN_ready_o are both high.
REQ-018 reqN_ready_o SHALL be combinational, high only in IDLE, and high for at most one requester, the winner.
REQ-019 Winner: if only one valid is high, that requester; if both, the requester not equal to last_grant.
REQ-020 On transfer at cycle T: tx_data_o <= reqN_data_i, grant_o and last_grant <= N, and the FSM enters SEND at T+1.
REQ-021 tx_ready_o SHALL be high in SEND only; tx_data_o SHALL be stable throughout SEND.
REQ-022 In SEND, a 20-bit counter SHALL count cycles from 0; tx_valid_i high -> GAP next cycle, counter cleared.
REQ-023 In SEND, counter == TIMEOUT_CYC-1 with tx_valid_i low -> timeout_o pulse that cycle, byte dropped, GAP next.
REQ-024 tx_valid_i and timeout on the same cycle SHALL be treated as completion; no timeout_o pulse.
REQ-025 GAP SHALL last exactly GAP_CYC cycles, then IDLE; no acceptance occurs during GAP.
REQ-026 tx_valid_i outside SEND SHALL be ignored.
REQ-027 Requester valid deasserting without transfer SHALL be legal; no state change results.
REQ-028 Minimum request-to-request spacing: 1 IDLE + SEND + GAP_CYC cycles.

Reset
REQ-029 Reset state: FSM IDLE; tx_ready_o 0; tx_data_o 8'h00; grant_o 0; busy_o 0; timeout_o 0; counters 0; last_grant 1.
REQ-030 Reset asserted mid-SEND SHALL drop tx_ready_o to 0 immediately (asynchronously); the in-flight byte is discarded.
REQ-031 After release, a requester SHALL wait at least one clock edge before acceptance.

Verification (GAP_CYC=2, TIMEOUT_CYC=20, uart_tx model pulses tx_valid_i 10 cycles after tx_ready_o rises)
REQ-032 req0 valid alone, data 8'h6C -> req0_ready_o high for 1 cycle; tx_data_o 8'h6C with tx_ready_o high for 10 cycles; 2 GAP cycles; then IDLE.
REQ-033 Both valid continuously, req0 8'h88, req1 8'h11, from reset -> grants alternate 0,1,0,1; tx_data_o sequence 88,11,88,11.
REQ-034 Model never pulses tx_valid_i -> timeout_o pulses on SEND cycle 20; FSM in GAP next cycle; busy_o low after GAP.
REQ-035 tx_valid_i on SEND cycle 20 -> completion; timeout_o stays 0.
REQ-036 nreset_i low on SEND cycle 5 -> tx_ready_o 0 and busy_o 0 before the next edge; after release, a new req1 byte is accepted normally.
REQ-037 tx_valid_i pulsed during IDLE and GAP -> no state or output change.
